// File: rtl/sad_pkg.sv
// Shared constants, lane slicing and pipeline records for the X2 SAD minimum reducer.
package sad_pkg;

  localparam int unsigned LANES   = 16;
  localparam int unsigned DW      = 32;
  localparam int unsigned IDXW    = 8;
  localparam int unsigned LANE_IW = 4;
  localparam int unsigned BEAT_W  = IDXW - LANE_IW;
  localparam int unsigned GROUPS  = LANES / 4;

  localparam logic [DW-1:0] SAD_MAX = '1;

  // Lane i of the SAD bus lives at bits [DW*i + DW-1 : DW*i].
  function automatic logic [DW-1:0] lane_slice(input logic [LANES*DW-1:0] bus,
                                               input int unsigned lane);
    return bus[lane*DW +: DW];
  endfunction

  typedef struct packed {
    logic [DW-1:0]      sad;
    logic [LANE_IW-1:0] lane;
  } grp_t;

  typedef struct packed {
    grp_t [GROUPS-1:0]  grp;
    logic [BEAT_W-1:0]  beat;
    logic               valid;
    logic               clear;
    logic               last;
    logic               ovf;
  } stage_a_t;

  typedef struct packed {
    grp_t               best;
    logic [BEAT_W-1:0]  beat;
    logic               valid;
    logic               clear;
    logic               last;
    logic               ovf;
  } stage_b_t;

endpackage

// File: rtl/sad_min4.sv
// Combinational 4-input unsigned minimum; ties resolve to the lowest input position.
module sad_min4 #(
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 4
) (
  input  logic [3:0][DW-1:0] i_val,
  input  logic [3:0][IW-1:0] i_idx,
  output logic [DW-1:0]      o_min_c,
  output logic [IW-1:0]      o_idx_c
);

  logic          w_sel01;
  logic          w_sel23;
  logic          w_selhi;
  logic [DW-1:0] w_m01;
  logic [DW-1:0] w_m23;
  logic [IW-1:0] w_i01;
  logic [IW-1:0] w_i23;

  // Strict less-than keeps the lower position on equal values.
  assign w_sel01 = i_val[1] < i_val[0];
  assign w_sel23 = i_val[3] < i_val[2];
  assign w_m01   = w_sel01 ? i_val[1] : i_val[0];
  assign w_i01   = w_sel01 ? i_idx[1] : i_idx[0];
  assign w_m23   = w_sel23 ? i_val[3] : i_val[2];
  assign w_i23   = w_sel23 ? i_idx[3] : i_idx[2];

  assign w_selhi = w_m23 < w_m01;
  assign o_min_c = w_selhi ? w_m23 : w_m01;
  assign o_idx_c = w_selhi ? w_i23 : w_i01;

endmodule

// File: rtl/x2_sad_min_reducer.sv
// Reduces sixteen X2 SAD lanes per beat to a running frame minimum with index,
// through a 16->4 stage, a 4->1 stage and a merge/accumulate register.
module x2_sad_min_reducer #(
  parameter int unsigned LANES = sad_pkg::LANES,
  parameter int unsigned DW    = sad_pkg::DW,
  parameter int unsigned IDXW  = sad_pkg::IDXW
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  X2_minRegWrite,
  input  logic                  X2_minClear,
  input  logic                  X2_minLast,
  input  logic [LANES*DW-1:0]   X2_SubberBus,
  output logic [DW-1:0]         min_sad,
  output logic [IDXW-1:0]       min_index,
  output logic                  min_valid,
  output logic                  result_valid,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned GROUPS = LANES / 4;
  localparam int unsigned LIW    = sad_pkg::LANE_IW;
  localparam int unsigned BW     = IDXW - LIW;
  localparam int unsigned CNTW   = BW + 1;
  localparam logic [BW-1:0] BEAT_MAX = '1;

  logic [CNTW-1:0]       r_cnt;
  sad_pkg::stage_a_t     w_a;
  sad_pkg::stage_a_t     r_a;
  sad_pkg::stage_b_t     w_b;
  sad_pkg::stage_b_t     r_b;

  logic [GROUPS-1:0][DW-1:0]  w_gmin;
  logic [GROUPS-1:0][LIW-1:0] w_glane;
  logic [3:0][DW-1:0]         w_bval;
  logic [3:0][LIW-1:0]        w_bidx;
  logic [DW-1:0]              w_bmin;
  logic [LIW-1:0]             w_blane;
  logic [IDXW-1:0]            w_bindex;

  // Stage A tree: one 4-input min per group of four adjacent lanes.
  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    logic [3:0][DW-1:0]  w_val;
    logic [3:0][LIW-1:0] w_idx;
    for (genvar k = 0; k < 4; k++) begin : g_lane
      assign w_val[k] = sad_pkg::lane_slice(X2_SubberBus, 4*g + k);
      assign w_idx[k] = LIW'(4*g + k);
    end
    sad_min4 #(.DW(DW), .IW(LIW)) u_min4 (
      .i_val   (w_val),
      .i_idx   (w_idx),
      .o_min_c (w_gmin[g]),
      .o_idx_c (w_glane[g])
    );
  end

  // Beat number is fixed at the input so later clears cannot renumber in-flight beats.
  always_comb begin
    w_a       = '0;
    w_a.valid = X2_minRegWrite;
    w_a.clear = X2_minClear;
    w_a.last  = X2_minRegWrite & X2_minLast;
    w_a.ovf   = X2_minRegWrite & ~X2_minClear & r_cnt[BW];
    if (X2_minClear) begin
      w_a.beat = '0;
    end else if (r_cnt[BW]) begin
      w_a.beat = BEAT_MAX;
    end else begin
      w_a.beat = r_cnt[BW-1:0];
    end
    for (int g = 0; g < GROUPS; g++) begin
      w_a.grp[g].sad  = w_gmin[g];
      w_a.grp[g].lane = w_glane[g];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (X2_minClear) begin
      r_cnt <= X2_minRegWrite ? CNTW'(1) : '0;
    end else if (X2_minRegWrite && !r_cnt[BW]) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  always_comb begin
    w_bval = '0;
    w_bidx = '0;
    for (int g = 0; g < GROUPS; g++) begin
      w_bval[g] = r_a.grp[g].sad;
      w_bidx[g] = r_a.grp[g].lane;
    end
  end

  sad_min4 #(.DW(DW), .IW(LIW)) u_min4_b (
    .i_val   (w_bval),
    .i_idx   (w_bidx),
    .o_min_c (w_bmin),
    .o_idx_c (w_blane)
  );

  always_comb begin
    w_b           = '0;
    w_b.best.sad  = w_bmin;
    w_b.best.lane = w_blane;
    w_b.beat      = r_a.beat;
    w_b.valid     = r_a.valid;
    w_b.clear     = r_a.clear;
    w_b.last      = r_a.last;
    w_b.ovf       = r_a.ovf;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a  <= '0;
      r_b  <= '0;
      busy <= 1'b0;
    end else begin
      r_a  <= w_a;
      r_b  <= w_b;
      busy <= w_a.valid | r_a.valid;
    end
  end

  assign w_bindex = IDXW'({r_b.beat, r_b.best.lane});

  // Merge: a clear restarts the frame from its own beat (or empties it).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      min_sad      <= sad_pkg::SAD_MAX;
      min_index    <= '0;
      min_valid    <= 1'b0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= r_b.valid & r_b.last;
      if (r_b.clear) begin
        overflow <= 1'b0;
        if (r_b.valid) begin
          min_sad   <= r_b.best.sad;
          min_index <= w_bindex;
          min_valid <= 1'b1;
        end else begin
          min_sad   <= sad_pkg::SAD_MAX;
          min_index <= '0;
          min_valid <= 1'b0;
        end
      end else if (r_b.valid) begin
        if (!min_valid || (r_b.best.sad < min_sad)) begin
          min_sad   <= r_b.best.sad;
          min_index <= w_bindex;
        end
        min_valid <= 1'b1;
        if (r_b.ovf) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
